// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: post-EX producer tracking, forward select and load-use stall; FWD_STALL_COUNT_EN adds a saturating stall counter
module fwd_scoreboard #(
  parameter int DEPTH = 2,
  parameter int NUM_SRC = 2,
  parameter int LOAD_READY = 2,
  localparam int SELW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      ex_valid,
  input  logic                      ex_regwrite,
  input  logic                      ex_is_load,
  input  logic [4:0]                ex_rd,
  input  logic [NUM_SRC*5-1:0]      src_rs,
  input  logic [NUM_SRC-1:0]        src_used,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall,
  output logic [31:0]               stall_count
);
  logic [DEPTH:1]      valid_q, valid_d, ld_q, ld_d;
  logic [DEPTH:1][4:0] rd_q, rd_d;
  logic [NUM_SRC-1:0]  hz;
  always_comb begin
    fwd_sel = '0;
    hz = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = DEPTH; k >= 1; k--)
        if (src_used[i] && valid_q[k] && rd_q[k] == src_rs[i*5 +: 5] && src_rs[i*5 +: 5] != 5'd0) begin
          fwd_sel[i*SELW +: SELW] = SELW'(k);
          hz[i] = ld_q[k] && (k < LOAD_READY);
        end
    stall = ex_valid && |hz;
  end
  always_comb begin
    valid_d = valid_q;
    rd_d = rd_q;
    ld_d = ld_q;
    if (advance) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        rd_d[k] = rd_q[k-1];
        ld_d[k] = ld_q[k-1];
      end
      valid_d[1] = ex_valid && ex_regwrite && ex_rd != 5'd0 && !stall && !flush;
      rd_d[1] = ex_rd;
      ld_d[1] = ex_is_load;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_q <= '0;
      ld_q <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q <= rd_d;
      ld_q <= ld_d;
    end
  end
`ifdef FWD_STALL_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = (stall && advance && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 32'd0 : cnt_d;
  assign stall_count = cnt_q;
`else
  assign stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed checks of forwarding, load-use stall, flush and reset on default and DEPTH=4 instances
module tb_fwd_scoreboard;
  logic clk = 1'b0, rst, advance, flush, ex_valid, ex_regwrite, ex_is_load;
  logic [4:0] ex_rd;
  logic [9:0] src_rs;
  logic [1:0] src_used;
  logic [3:0] fwd_sel_a;
  logic [5:0] fwd_sel_b;
  logic stall_a, stall_b;
  logic [31:0] cnt_a, cnt_b;
  int errors = 0, checks = 0;
`ifdef FWD_STALL_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  always #5 clk = ~clk;
  fwd_scoreboard u_a (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .src_rs(src_rs),
    .src_used(src_used), .fwd_sel(fwd_sel_a), .stall(stall_a), .stall_count(cnt_a)
  );
  fwd_scoreboard #(.DEPTH(4), .LOAD_READY(3)) u_b (
    .clk(clk), .rst(rst), .advance(advance), .flush(flush), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .src_rs(src_rs),
    .src_used(src_used), .fwd_sel(fwd_sel_b), .stall(stall_b), .stall_count(cnt_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ex(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    ex_valid = v;
    ex_regwrite = rw;
    ex_is_load = ld;
    ex_rd = rd;
    src_rs = {rs1, rs0};
    src_used = used;
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    advance = 1'b1;
    flush = 1'b0;
    set_ex(1, 1, 1, 5, 5, 5, 2'b11);
    do_reset();
    set_ex(1, 1, 0, 6, 5, 7, 2'b11);
    check("rst_fwd", fwd_sel_a, 0);
    check("rst_stall", stall_a, 0);
    check("rst_cnt", cnt_a, 0);
    set_ex(1, 1, 0, 5, 1, 2, 2'b00);
    tick();
    set_ex(1, 1, 0, 6, 5, 0, 2'b01);
    check("alu_raw_fwd", fwd_sel_a, 1);
    check("alu_raw_stall", stall_a, 0);
    tick();
    set_ex(1, 0, 0, 0, 5, 6, 2'b11);
    check("alu_raw_wb", fwd_sel_a, 6);
    do_reset();
    set_ex(1, 1, 1, 7, 0, 0, 2'b00);
    tick();
    set_ex(0, 1, 0, 8, 0, 7, 2'b10);
    check("lu_noex_stall", stall_a, 0);
    check("lu_noex_fwd", fwd_sel_a, 4);
    set_ex(1, 1, 0, 8, 0, 7, 2'b10);
    check("lu_stall", stall_a, 1);
    check("lu_fwd_mem", fwd_sel_a, 4);
    advance = 1'b0;
    tick();
    check("lu_hold_stall", stall_a, 1);
    check("lu_hold_cnt", cnt_a, 0);
    advance = 1'b1;
    tick();
    check("lu_after_stall", stall_a, 0);
    check("lu_fwd_wb", fwd_sel_a, 8);
    check("lu_cnt", cnt_a, CNT_ON);
    tick();
    set_ex(1, 0, 0, 0, 8, 0, 2'b01);
    check("lu_consumer_in", fwd_sel_a, 1);
    do_reset();
    set_ex(1, 1, 0, 0, 0, 0, 2'b00);
    tick();
    set_ex(1, 1, 0, 3, 0, 0, 2'b11);
    check("x0_fwd", fwd_sel_a, 0);
    tick();
    set_ex(1, 0, 0, 0, 3, 0, 2'b00);
    check("unused_fwd", fwd_sel_a, 0);
    set_ex(1, 0, 0, 0, 3, 0, 2'b01);
    check("used_fwd", fwd_sel_a, 1);
    do_reset();
    set_ex(1, 1, 0, 9, 0, 0, 2'b00);
    tick();
    tick();
    set_ex(1, 0, 0, 0, 9, 0, 2'b01);
    check("dbl_youngest", fwd_sel_a, 1);
    set_ex(1, 1, 1, 9, 0, 0, 2'b00);
    tick();
    set_ex(1, 1, 0, 10, 9, 0, 2'b01);
    check("fl_stall", stall_a, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_ex(1, 0, 0, 0, 9, 10, 2'b11);
    check("fl_fwd", fwd_sel_a, 2);
    check("fl_stall_drop", stall_a, 0);
    check("fl_cnt", cnt_a, CNT_ON);
    do_reset();
    set_ex(1, 1, 1, 7, 0, 0, 2'b00);
    tick();
    set_ex(1, 0, 0, 0, 0, 0, 2'b00);
    tick();
    set_ex(1, 1, 0, 8, 7, 0, 2'b01);
    check("d4_stall", stall_b, 1);
    check("d4_fwd2", fwd_sel_b, 2);
    tick();
    check("d4_ready_stall", stall_b, 0);
    check("d4_fwd3", fwd_sel_b, 3);
    check("d4_cnt", cnt_b, CNT_ON);
    set_ex(1, 1, 1, 4, 0, 0, 2'b00);
    tick();
    set_ex(1, 1, 0, 5, 4, 0, 2'b01);
    check("d4_stall2", stall_b, 1);
    check("d4_fwd1", fwd_sel_b, 1);
    do_reset();
    check("d4_rst_fwd", fwd_sel_b, 0);
    check("d4_rst_stall", stall_b, 0);
    check("d4_rst_cnt", cnt_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
